// File: rtl/uart_mmio_bridge.sv
// Bus-facing register block for the UART pair: TX FIFO + frame sequencer, single-byte RX
// holding register with overrun/parity tracking, and a STATUS/CTRL register map.
module uart_mmio_bridge #(
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        transmit,
    output logic [7:0]  dataToTransmit,
    input  logic        finished_tx,
    input  logic [7:0]  receivedData,
    input  logic        rxInterrupt,
    input  logic        parityError,
    output logic        clearInterrupt,
    output logic        irq
);
    localparam int AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} txState_t;
    typedef enum logic {RX_IDLE, RX_ACK} rxState_t;

    txState_t    txState, txStateNext;
    rxState_t    rxState, rxStateNext;

    logic [7:0]  txMem [TX_DEPTH];
    logic [AW:0] wrPtr, rdPtr;
    logic [7:0]  txHead, txDataReg;
    logic        txEmpty, txFull, txPush, txPop, txWrite;
    logic        finishedPrev, finishedRise;

    logic [7:0]  rxByte;
    logic        rxValid, rxParity, rxOverrun, rxRead, rxEvent, clearIntReg;
    logic        txDrop, ctrlClear;
    logic [1:0]  regSel;
    logic [31:0] statusWord;
    logic        unusedBits;

    assign regSel     = addr[3:2];
    assign txWrite    = wr_en && (regSel == 2'd0);
    assign ctrlClear  = wr_en && (regSel == 2'd3) && wr_data[0];
    assign rxRead     = rd_en && (regSel == 2'd1) && rxValid;
    assign unusedBits = ^{wr_data[31:8], addr[1:0]};

    // Full when the pointers differ only in their wrap bit.
    assign txEmpty = (wrPtr == rdPtr);
    assign txFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign txHead  = txMem[rdPtr[AW-1:0]];
    assign txPop   = (txState == TX_START);
    assign txPush  = txWrite && (!txFull || txPop);

    assign finishedRise = finished_tx && !finishedPrev;

    always_ff @(posedge clk) begin
        if (txPush) begin
            txMem[wrPtr[AW-1:0]] <= wr_data[7:0];
        end
    end

    always_comb begin
        txStateNext    = txState;
        transmit       = 1'b0;
        dataToTransmit = txDataReg;
        case (txState)
            TX_IDLE: begin
                if (!txEmpty || txPush) begin
                    txStateNext = TX_START;
                end
            end
            TX_START: begin
                transmit       = 1'b1;
                dataToTransmit = txHead;
                txStateNext    = TX_WAIT;
            end
            TX_WAIT: begin
                if (finishedRise) begin
                    txStateNext = TX_IDLE;
                end
            end
            default: txStateNext = TX_IDLE;
        endcase
    end

    // A read that clears rx_valid defers any pending capture to the next idle evaluation.
    always_comb begin
        rxStateNext = rxState;
        rxEvent     = 1'b0;
        case (rxState)
            RX_IDLE: begin
                if (rxInterrupt && !rxRead) begin
                    rxEvent     = 1'b1;
                    rxStateNext = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!rxInterrupt) begin
                    rxStateNext = RX_IDLE;
                end
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txState      <= TX_IDLE;
            wrPtr        <= '0;
            rdPtr        <= '0;
            txDataReg    <= 8'h00;
            txDrop       <= 1'b0;
            // Treat the line as already high so a level present at reset is not an edge.
            finishedPrev <= 1'b1;
        end else begin
            txState      <= txStateNext;
            finishedPrev <= finished_tx;
            if (txPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (txPop) begin
                rdPtr     <= rdPtr + 1'b1;
                txDataReg <= txHead;
            end
            if (ctrlClear) begin
                txDrop <= 1'b0;
            end
            if (txWrite && !txPush) begin
                txDrop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxState     <= RX_IDLE;
            rxByte      <= 8'h00;
            rxValid     <= 1'b0;
            rxParity    <= 1'b0;
            rxOverrun   <= 1'b0;
            clearIntReg <= 1'b0;
        end else begin
            rxState     <= rxStateNext;
            clearIntReg <= rxEvent;
            if (ctrlClear) begin
                rxParity  <= 1'b0;
                rxOverrun <= 1'b0;
            end
            if (rxRead) begin
                rxValid <= 1'b0;
            end
            if (rxEvent) begin
                // Parity is sticky across every received frame, including discarded ones.
                rxParity <= rxParity | parityError;
                if (!rxValid) begin
                    rxByte  <= receivedData;
                    rxValid <= 1'b1;
                end else begin
                    rxOverrun <= 1'b1;
                end
            end
        end
    end

    assign clearInterrupt = clearIntReg;
    assign irq            = rxValid;

    assign statusWord = {25'd0, txDrop, (txState != TX_IDLE), rxOverrun, rxParity,
                         rxValid, txEmpty, txFull};

    always_comb begin
        rd_data = 32'd0;
        case (regSel)
            2'd1:    rd_data = {24'd0, rxByte};
            2'd2:    rd_data = statusWord;
            default: rd_data = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed scenarios plus a randomized register-level run against a queue-based model
// of the bridge's software-visible behaviour.
module tb_uart_mmio_bridge;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic        wr_en, rd_en;
    logic [31:0] wr_data, rd_data;
    logic        transmit;
    logic [7:0]  dataToTransmit;
    logic        finished_tx;
    logic [7:0]  receivedData;
    logic        rxInterrupt, parityError, clearInterrupt, irq;

    always #5 clk = ~clk;

    uart_mmio_bridge #(.TX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_data(rd_data), .transmit(transmit),
        .dataToTransmit(dataToTransmit), .finished_tx(finished_tx),
        .receivedData(receivedData), .rxInterrupt(rxInterrupt),
        .parityError(parityError), .clearInterrupt(clearInterrupt), .irq(irq)
    );

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] seenQ[$];
    int clearCount = 0;

    always @(negedge clk) begin
        if (transmit === 1'b1) seenQ.push_back(dataToTransmit);
        if (clearInterrupt === 1'b1) clearCount++;
    end

    // Reference model state
    logic [7:0] mQ[$];
    logic [7:0] expQ[$];
    logic       mInFlight, mDrop, mRxValid, mParity, mOverrun;
    logic [7:0] mByte, mRxByte;
    int         expClear, clearBase, seenIdx;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic peekReg(input logic [3:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b0;
        #1;
        d = rd_data;
    endtask

    task automatic busRead(input logic [3:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b1;
        #1;
        d = rd_data;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic finishPulse();
        finished_tx = 1'b1;
        step(1);
        finished_tx = 1'b0;
    endtask

    task automatic rxInject(input logic [7:0] b, input logic p);
        receivedData = b;
        parityError  = p;
        rxInterrupt  = 1'b1;
        step(2);
        rxInterrupt  = 1'b0;
        parityError  = 1'b0;
        step(2);
    endtask

    task automatic doReset();
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; addr = 4'h0; wr_data = 32'd0;
        finished_tx = 1'b0; rxInterrupt = 1'b0; parityError = 1'b0; receivedData = 8'h00;
        step(3);
        rst = 1'b0;
        mQ.delete();
        mInFlight = 1'b0; mDrop = 1'b0; mRxValid = 1'b0; mParity = 1'b0; mOverrun = 1'b0;
        mByte = 8'h00; mRxByte = 8'h00;
        expClear = 0;
        clearBase = clearCount;
    endtask

    function automatic logic [31:0] modelStatus();
        return {25'd0, mDrop, mInFlight, mOverrun, mParity, mRxValid,
                (mQ.size() == 0), (mQ.size() == DEPTH)};
    endfunction

    task automatic modelSettle();
        if (!mInFlight && mQ.size() > 0) begin
            mByte = mQ.pop_front();
            mInFlight = 1'b1;
            expQ.push_back(mByte);
        end
    endtask

    task automatic compareTx(input string ctx);
        int n;
        checkValue({ctx, "/txCount"}, seenQ.size(), expQ.size());
        n = (seenQ.size() < expQ.size()) ? seenQ.size() : expQ.size();
        for (int i = seenIdx; i < n; i++) begin
            checkValue($sformatf("%s/txByte%0d", ctx, i), {24'd0, seenQ[i]}, {24'd0, expQ[i]});
        end
        if (n > seenIdx) seenIdx = n;
    endtask

    task automatic compareAll(input string ctx);
        logic [31:0] st;
        peekReg(4'h8, st);
        checkValue({ctx, "/status"}, st, modelStatus());
        checkValue({ctx, "/irq"}, {31'd0, irq}, {31'd0, mRxValid});
        if (mInFlight) checkValue({ctx, "/txHold"}, {24'd0, dataToTransmit}, {24'd0, mByte});
        checkValue({ctx, "/clearCount"}, clearCount - clearBase, expClear);
        compareTx(ctx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic        p;
        int          op;
        seenIdx = 0;

        // Reset state
        doReset();
        peekReg(4'h8, d);
        checkValue("rst/status", d, 32'h02);
        checkValue("rst/transmit", {31'd0, transmit}, 32'd0);
        checkValue("rst/clearInt", {31'd0, clearInterrupt}, 32'd0);
        checkValue("rst/irq", {31'd0, irq}, 32'd0);
        checkValue("rst/txData", {24'd0, dataToTransmit}, 32'd0);

        // Back-to-back TX writes
        busWrite(4'h0, 32'h55);
        checkValue("tx1/transmit", {31'd0, transmit}, 32'd1);
        checkValue("tx1/data", {24'd0, dataToTransmit}, 32'h55);
        peekReg(4'h8, d);
        checkValue("tx1/status", d, 32'h20);
        busWrite(4'h0, 32'hA3);
        checkValue("tx2/transmitLow", {31'd0, transmit}, 32'd0);
        checkValue("tx2/hold", {24'd0, dataToTransmit}, 32'h55);
        step(20);
        checkValue("tx2/holdLong", {24'd0, dataToTransmit}, 32'h55);
        expQ.push_back(8'h55);
        compareTx("tx2");
        finishPulse();
        step(1);
        checkValue("tx3/transmit", {31'd0, transmit}, 32'd1);
        checkValue("tx3/data", {24'd0, dataToTransmit}, 32'hA3);
        step(1);
        checkValue("tx3/transmitLow", {31'd0, transmit}, 32'd0);
        finishPulse();
        step(3);
        expQ.push_back(8'hA3);
        compareTx("tx3");
        peekReg(4'h8, d);
        checkValue("tx3/status", d, 32'h02);

        // Overfill while stalled, clear drop, push+pop when full
        doReset();
        for (int k = 0; k < 6; k++) busWrite(4'h0, 32'h10 + k);
        peekReg(4'h8, d);
        checkValue("fill/status", d, 32'h61);
        busWrite(4'hC, 32'h1);
        peekReg(4'h8, d);
        checkValue("fill/ctrlClear", d, 32'h21);
        finishPulse();
        step(1);
        checkValue("fill/transmit", {31'd0, transmit}, 32'd1);
        checkValue("fill/data", {24'd0, dataToTransmit}, 32'h11);
        busWrite(4'h0, 32'h16);
        peekReg(4'h8, d);
        checkValue("fill/pushPop", d, 32'h21);
        for (int k = 0; k < 5; k++) begin
            finishPulse();
            step(3);
        end
        expQ.push_back(8'h10); expQ.push_back(8'h11); expQ.push_back(8'h12);
        expQ.push_back(8'h13); expQ.push_back(8'h14); expQ.push_back(8'h16);
        compareTx("fill");
        peekReg(4'h8, d);
        checkValue("fill/drained", d, 32'h02);

        // Single RX byte
        doReset();
        receivedData = 8'h3C;
        rxInterrupt  = 1'b1;
        step(1);
        checkValue("rx1/irq", {31'd0, irq}, 32'd1);
        checkValue("rx1/clearInt", {31'd0, clearInterrupt}, 32'd1);
        step(1);
        checkValue("rx1/clearIntLow", {31'd0, clearInterrupt}, 32'd0);
        rxInterrupt = 1'b0;
        step(2);
        busRead(4'h4, d);
        checkValue("rx1/data", d, 32'h3C);
        checkValue("rx1/irqAfter", {31'd0, irq}, 32'd0);
        peekReg(4'h8, d);
        checkValue("rx1/status", d, 32'h02);
        checkValue("rx1/clearCount", clearCount - clearBase, 32'd1);

        // Overrun with parity on the discarded byte
        rxInject(8'h11, 1'b0);
        rxInject(8'h22, 1'b1);
        peekReg(4'h8, d);
        checkValue("rx2/status", d, 32'h1E);
        busRead(4'h4, d);
        checkValue("rx2/data", d, 32'h11);

        // Read and new capture in the same cycle
        busWrite(4'hC, 32'h1);
        rxInject(8'h44, 1'b0);
        receivedData = 8'h55;
        rxInterrupt  = 1'b1;
        busRead(4'h4, d);
        checkValue("rx3/oldByte", d, 32'h44);
        checkValue("rx3/irqCleared", {31'd0, irq}, 32'd0);
        step(1);
        checkValue("rx3/irqNew", {31'd0, irq}, 32'd1);
        peekReg(4'h4, d);
        checkValue("rx3/newByte", d, 32'h55);
        peekReg(4'h8, d);
        checkValue("rx3/status", d, 32'h06);
        rxInterrupt = 1'b0;
        step(2);

        // Reset mid-frame
        doReset();
        for (int k = 0; k < 4; k++) busWrite(4'h0, 32'h31 + k);
        expQ.push_back(8'h31);
        rst = 1'b1;
        step(1);
        peekReg(4'h8, d);
        checkValue("rst2/status", d, 32'h02);
        checkValue("rst2/transmit", {31'd0, transmit}, 32'd0);
        rst = 1'b0;
        step(10);
        finishPulse();
        step(5);
        compareTx("rst2");

        // Randomized run
        doReset();
        for (int it = 0; it < 200; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1, 2: begin
                    b = 8'($urandom);
                    busWrite(4'h0, {24'd0, b});
                    if (mQ.size() < DEPTH) mQ.push_back(b);
                    else mDrop = 1'b1;
                end
                3, 4: begin
                    finishPulse();
                    mInFlight = 1'b0;
                end
                5: begin
                    b = 8'($urandom);
                    p = ($urandom_range(0, 3) == 0);
                    rxInject(b, p);
                    expClear++;
                    mParity = mParity | p;
                    if (mRxValid) mOverrun = 1'b1;
                    else begin
                        mRxValid = 1'b1;
                        mRxByte  = b;
                    end
                end
                6: begin
                    busRead(4'h4, d);
                    checkValue($sformatf("rnd%0d/rxdata", it), d, {24'd0, mRxByte});
                    mRxValid = 1'b0;
                end
                default: begin
                    p = 1'($urandom_range(0, 1));
                    busWrite(4'hC, {31'd0, p});
                    if (p) begin
                        mDrop = 1'b0; mParity = 1'b0; mOverrun = 1'b0;
                    end
                    busRead(($urandom_range(0, 1) != 0) ? 4'h0 : 4'hC, d);
                    checkValue($sformatf("rnd%0d/wrOnlyRead", it), d, 32'd0);
                end
            endcase
            step(3);
            modelSettle();
            compareAll($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
